pht_gshare: RTL

Parametrised gshare pattern history table for the IF-stage branch predictor. It provides `NPORT` combinational prediction lookups per cycle from a table of 2-bit saturating counters. Each lookup index is the fetch PC hashed with a speculative global history register (GHR). Corrections from execute update the table through a registered read-modify-write stage, and mispredicts repair the GHR.

---
 rtl/pht_gshare_if.sv | 30 +++
 rtl/pht_gshare.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pht_gshare_if.sv
// Bundle of search, speculative-history and correction signals between the fetch
// pipeline and the gshare pattern history table.
interface pht_gshare_if #(
  parameter int NPORT     = 2,
  parameter int HIST_BITS = 8
);
  logic [32*NPORT-1:0]  search_addr_i;
  logic [NPORT-1:0]     branch_flag_o;
  logic [HIST_BITS-1:0] search_ghr_o;
  logic                 spec_valid_i;
  logic                 spec_taken_i;
  logic                 corr_valid_i;
  logic [31:0]          corr_index_i;
  logic [HIST_BITS-1:0] corr_ghr_i;
  logic                 corr_branch_flag_i;
  logic                 corr_mispredict_i;
  logic                 init_busy_o;

  modport master (
    output search_addr_i, spec_valid_i, spec_taken_i, corr_valid_i, corr_index_i,
           corr_ghr_i, corr_branch_flag_i, corr_mispredict_i,
    input  branch_flag_o, search_ghr_o, init_busy_o
  );

  modport slave (
    input  search_addr_i, spec_valid_i, spec_taken_i, corr_valid_i, corr_index_i,
           corr_ghr_i, corr_branch_flag_i, corr_mispredict_i,
    output branch_flag_o, search_ghr_o, init_busy_o
  );
endinterface

// File: rtl/pht_gshare.sv
// Gshare pattern history table of 2-bit counters with init sweep and RMW correction pipe.
// Define PHT_GSHARE_EN to enable GHR hashing; otherwise the index is PC bits only.
module pht_gshare #(
  parameter int         PHT_BITS  = 10,
  parameter int         NPORT     = 2,
  parameter int         HIST_BITS = 8,
  parameter logic [1:0] CNT_INIT  = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  pht_gshare_if.slave bus
);

  localparam int DEPTH = 1 << PHT_BITS;

  typedef enum logic {INIT, RUN} state_e;

  state_e               state_q, state_d;
  logic [PHT_BITS-1:0]  ptr_q, ptr_d;
  logic [1:0]           pht_q [DEPTH];

  logic                 c1_valid_q, c1_valid_d;
  logic                 c1_taken_q, c1_taken_d;
  logic [PHT_BITS-1:0]  c1_idx_q, c1_idx_d;
  logic                 c2_valid_q, c2_valid_d;
  logic [PHT_BITS-1:0]  c2_idx_q, c2_idx_d;
  logic [1:0]           c2_cnt_q, c2_cnt_d;

  logic                 wr_en;
  logic [PHT_BITS-1:0]  wr_idx;
  logic [1:0]           wr_cnt;
  logic [1:0]           cur_cnt;
  logic [1:0]           upd_cnt;
  logic [HIST_BITS-1:0] search_ghr;
  logic [HIST_BITS-1:0] corr_hist;
  logic [NPORT-1:0]     flags;

  function automatic logic [PHT_BITS-1:0] hash(input logic [31:0] pc,
                                               input logic [HIST_BITS-1:0] h);
    return pc[PHT_BITS+1:2] ^ PHT_BITS'(h);
  endfunction

`ifdef PHT_GSHARE_EN
  logic [HIST_BITS-1:0] ghr_q, ghr_d;

  // Mispredict repair beats the speculative shift; truncating cast drops the oldest bit.
  always_comb begin
    ghr_d = ghr_q;
    if (state_q == INIT)
      ghr_d = '0;
    else if (bus.corr_valid_i && bus.corr_mispredict_i)
      ghr_d = HIST_BITS'({bus.corr_ghr_i, bus.corr_branch_flag_i});
    else if (bus.spec_valid_i)
      ghr_d = HIST_BITS'({ghr_q, bus.spec_taken_i});
  end

  always_ff @(posedge clk) begin
    if (!rst) ghr_q <= '0;
    else      ghr_q <= ghr_d;
  end

  assign search_ghr = ghr_q;
  assign corr_hist  = bus.corr_ghr_i;
`else
  logic unused_hist;
  assign unused_hist = ^{bus.corr_ghr_i, bus.spec_valid_i, bus.spec_taken_i,
                         bus.corr_mispredict_i};
  assign search_ghr  = '0;
  assign corr_hist   = '0;
`endif

  logic unused_pc;
  assign unused_pc = ^{bus.search_addr_i, bus.corr_index_i};

  always_comb begin
    flags = '0;
    for (int k = 0; k < NPORT; k++)
      flags[k] = (state_q == RUN) && pht_q[hash(bus.search_addr_i[32*k +: 32], search_ghr)][1];
  end

  assign bus.branch_flag_o = flags;
  assign bus.search_ghr_o  = search_ghr;
  assign bus.init_busy_o   = (state_q == INIT);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (&ptr_q) state_d = RUN;
    end
  end

  // C2 holds the last written counter so a following C1 read of the same entry sees it.
  always_comb begin
    c1_valid_d = bus.corr_valid_i && (state_q == RUN);
    c1_idx_d   = hash(bus.corr_index_i, corr_hist);
    c1_taken_d = bus.corr_branch_flag_i;
    cur_cnt    = (c2_valid_q && (c2_idx_q == c1_idx_q)) ? c2_cnt_q : pht_q[c1_idx_q];
    upd_cnt    = cur_cnt;
    if (c1_taken_q && cur_cnt != 2'b11)       upd_cnt = cur_cnt + 2'b01;
    else if (!c1_taken_q && cur_cnt != 2'b00) upd_cnt = cur_cnt - 2'b01;
    c2_valid_d = c1_valid_q;
    c2_idx_d   = c1_idx_q;
    c2_cnt_d   = upd_cnt;
  end

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = c1_idx_q;
    wr_cnt = upd_cnt;
    if (state_q == INIT) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
      wr_cnt = CNT_INIT;
    end else if (c1_valid_q) begin
      wr_en  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= INIT;
      ptr_q      <= '0;
      c1_valid_q <= 1'b0;
      c1_taken_q <= 1'b0;
      c1_idx_q   <= '0;
      c2_valid_q <= 1'b0;
      c2_idx_q   <= '0;
      c2_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      c1_valid_q <= c1_valid_d;
      c1_taken_q <= c1_taken_d;
      c1_idx_q   <= c1_idx_d;
      c2_valid_q <= c2_valid_d;
      c2_idx_q   <= c2_idx_d;
      c2_cnt_q   <= c2_cnt_d;
    end
  end

  // Counter storage has no reset; the init sweep fills it once reset is released.
  always_ff @(posedge clk) begin
    if (rst && wr_en) pht_q[wr_idx] <= wr_cnt;
  end

endmodule
